// File: rtl/binary_down_counter.sv
// binary_down_counter: loadable countdown timer with done pulse and optional auto-reload
// Ports:
//   clk          rising-edge system clock
//   reset        asynchronous active-low reset
//   en           count enable, one decrement per enabled COUNT cycle
//   abort        synchronous cancel, returns to IDLE with out cleared
//   auto_reload  sampled in EXPIRE, restarts from the last loaded value
//   load_valid   load request, only honoured while load_ready is high
//   load_value   start value for the countdown
//   load_ready   high in IDLE
//   out          current count
//   busy         high in COUNT
//   done         one-cycle pulse in EXPIRE
module binary_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             abort,
    input  logic             auto_reload,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, COUNT, EXPIRE} state_t;
    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_out_nx;
    logic [WIDTH-1:0] w_reload_nx;
    logic             w_accept;
    logic             w_last;
    logic             w_rearm;
    assign w_accept = load_valid & (r_state == IDLE);
    // out<=1 treated as the final step so the count can never underflow
    assign w_last   = (r_out <= WIDTH'(1));
    assign w_rearm  = auto_reload & (r_reload != '0);
    always_comb begin
        w_state_nx  = r_state;
        w_out_nx    = r_out;
        w_reload_nx = r_reload;
        if (abort) begin
            w_state_nx = IDLE;
            w_out_nx   = '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    w_out_nx    = load_value;
                    w_reload_nx = load_value;
                    w_state_nx  = (load_value != '0) ? COUNT : EXPIRE;
                end
                COUNT: if (en) begin
                    w_out_nx   = w_last ? '0 : r_out - WIDTH'(1);
                    w_state_nx = w_last ? EXPIRE : COUNT;
                end
                EXPIRE: begin
                    w_out_nx   = w_rearm ? r_reload : '0;
                    w_state_nx = w_rearm ? COUNT : IDLE;
                end
                default: begin
                    w_state_nx = IDLE;
                    w_out_nx   = '0;
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_out    <= '0;
            r_reload <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_out    <= w_out_nx;
            r_reload <= w_reload_nx;
        end
    end
    assign out        = r_out;
    assign busy       = (r_state == COUNT);
    assign done       = (r_state == EXPIRE);
    assign load_ready = (r_state == IDLE);
endmodule
